// File: rtl/hbus_pkg.sv
// Shared constants for the HyperBus two-port arbiter: port count, one-hot state
// encodings and the write-mask width helper.
package hbus_pkg;

  localparam int unsigned N_PORTS = 2;
  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE    = 4'b0001;
  localparam logic [STATE_W-1:0] ST_HOLD    = 4'b0010;
  localparam logic [STATE_W-1:0] ST_RELEASE = 4'b0100;
  localparam logic [STATE_W-1:0] ST_ERR     = 4'b1000;

  // Mask covers one bit per data byte plus one extra control bit.
  function automatic int unsigned mask_width(input int unsigned w);
    return (2 * w) / 8 + 1;
  endfunction

endpackage

// File: rtl/hbus_arbiter_if.sv
// One HyperBus request channel. The requester (or the arbiter towards the
// controller) uses the master modport; the side that serves it uses slave.
interface hbus_arbiter_if
  import hbus_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_LENGTH = 32
) ();

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned MW = mask_width(WIDTH);

  logic [ADDR_LENGTH-1:0] adr;
  logic [DW-1:0]          wdat;
  logic [MW-1:0]          mask;
  logic                   reg_space;
  logic                   rrq;
  logic                   wrq;

  logic [DW-1:0]          rdat;
  logic                   ready;
  logic                   valid;
  logic                   busy;
  logic                   gnt;
  logic                   err;
  logic                   timeout;

  modport master (
    output adr, wdat, mask, reg_space, rrq, wrq,
    input  rdat, ready, valid, busy, err
  );

  modport slave (
    input  adr, wdat, mask, reg_space, rrq, wrq,
    output rdat, ready, valid, gnt, err, timeout
  );

endinterface

// File: rtl/hbus_rr_pick.sv
// Two-requester round-robin picker; on contention the port not granted last wins.
module hbus_rr_pick
  import hbus_pkg::*;
(
  input  logic [N_PORTS-1:0] req_i,
  input  logic               last_i,
  output logic [N_PORTS-1:0] gnt_c_o
);

  always_comb begin
    gnt_c_o = '0;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = last_i ? 2'b01 : 2'b10;
      default: gnt_c_o = '0;
    endcase
  end

endmodule

// File: rtl/hbus_arbiter.sv
// Two-port arbiter in front of a single HyperBus controller.
// Optional request watchdog enabled by defining HBUS_ARB_WATCHDOG_EN.
module hbus_arbiter
  import hbus_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ADDR_LENGTH = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic           clk90,
  input  logic           rst,
  hbus_arbiter_if.slave  m0,
  hbus_arbiter_if.slave  m1,
  hbus_arbiter_if.master c
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned MW = mask_width(WIDTH);

  logic [STATE_W-1:0]     state_q, state_d;
  logic [N_PORTS-1:0]     gnt_q, gnt_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;

  logic [N_PORTS-1:0]     rrq_c, wrq_c, req_c, pick_c, blk_c, tmo_c;
  logic                   sel_c, cur_rrq_c, cur_wrq_c, hold_c, wd_fire_c;
  logic [ADDR_LENGTH-1:0] adr_c;
  logic [DW-1:0]          wdat_c;
  logic [MW-1:0]          mask_c;
  logic                   reg_space_c;

  assign rrq_c  = {m1.rrq, m0.rrq};
  assign wrq_c  = {m1.wrq, m0.wrq};
  assign req_c  = (rrq_c | wrq_c) & ~blk_c;
  assign hold_c = (state_q == ST_HOLD);
  assign sel_c  = gnt_q[1];

  hbus_rr_pick u_pick (
    .req_i   (req_c),
    .last_i  (last_q),
    .gnt_c_o (pick_c)
  );

  // Request bus follows the granted port.
  always_comb begin
    adr_c       = m0.adr;
    wdat_c      = m0.wdat;
    mask_c      = m0.mask;
    reg_space_c = m0.reg_space;
    cur_rrq_c   = m0.rrq;
    cur_wrq_c   = m0.wrq;
    if (sel_c) begin
      adr_c       = m1.adr;
      wdat_c      = m1.wdat;
      mask_c      = m1.mask;
      reg_space_c = m1.reg_space;
      cur_rrq_c   = m1.rrq;
      cur_wrq_c   = m1.wrq;
    end
  end

  assign c.adr       = adr_c;
  assign c.wdat      = wdat_c;
  assign c.mask      = mask_c;
  assign c.reg_space = reg_space_c;
  // A port raising both strobes gets a read.
  assign c.rrq       = hold_c & cur_rrq_c;
  assign c.wrq       = hold_c & cur_wrq_c & ~cur_rrq_c;

  // Next-state logic; a controller error overrides every state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (|pick_c) begin
          state_d = ST_HOLD;
          gnt_d   = pick_c;
          last_d  = pick_c[1];
        end
      end
      ST_HOLD: begin
        if ((!cur_rrq_c && !cur_wrq_c) || wd_fire_c) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!c.busy) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
        end
      end
      ST_ERR: begin
        gnt_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    if (c.err) begin
      state_d = ST_ERR;
      gnt_d   = '0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

`ifdef HBUS_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_PORTS-1:0] blk_q, blk_d;
  logic [N_PORTS-1:0] tmo_q, tmo_d;
  logic               idle_beat_c;

  assign idle_beat_c = hold_c && !c.ready && !c.valid;
  assign wd_fire_c   = idle_beat_c && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Silent-cycle counter, per-port block flags and the one-cycle timeout pulse.
  always_comb begin
    cnt_d = '0;
    blk_d = blk_q;
    tmo_d = '0;
    if (idle_beat_c && !wd_fire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    for (int n = 0; n < int'(N_PORTS); n++) begin
      if (!rrq_c[n] && !wrq_c[n]) begin
        blk_d[n] = 1'b0;
      end
      if (wd_fire_c && gnt_q[n]) begin
        blk_d[n] = 1'b1;
        tmo_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      blk_q <= '0;
      tmo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      blk_q <= blk_d;
      tmo_q <= tmo_d;
    end
  end

  assign blk_c = blk_q;
  assign tmo_c = tmo_q;
`else
  logic unused_timeout_cfg;

  assign wd_fire_c          = 1'b0;
  assign blk_c              = '0;
  assign tmo_c              = '0;
  assign unused_timeout_cfg = ^TIMEOUT;
`endif

  // Requester-side status: ready/valid reach only the granted port.
  assign m0.gnt     = gnt_q[0];
  assign m0.ready   = c.ready & gnt_q[0];
  assign m0.valid   = c.valid & gnt_q[0];
  assign m0.rdat    = c.rdat;
  assign m0.err     = err_q;
  assign m0.timeout = tmo_c[0];

  assign m1.gnt     = gnt_q[1];
  assign m1.ready   = c.ready & gnt_q[1];
  assign m1.valid   = c.valid & gnt_q[1];
  assign m1.rdat    = c.rdat;
  assign m1.err     = err_q;
  assign m1.timeout = tmo_c[1];

endmodule

// File: tb/tb_hbus_arbiter.sv
// Directed bench for hbus_arbiter; the watchdog section follows HBUS_ARB_WATCHDOG_EN.
module tb_hbus_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 32;
  localparam int unsigned TMO   = 16;

  logic clk90;
  logic rst;
  int   checks;
  int   errors;
  logic seen;

  hbus_arbiter_if #(.WIDTH(WIDTH), .ADDR_LENGTH(AW)) m0_if ();
  hbus_arbiter_if #(.WIDTH(WIDTH), .ADDR_LENGTH(AW)) m1_if ();
  hbus_arbiter_if #(.WIDTH(WIDTH), .ADDR_LENGTH(AW)) c_if ();

  hbus_arbiter #(.WIDTH(WIDTH), .ADDR_LENGTH(AW), .TIMEOUT(TMO)) dut (
    .clk90 (clk90),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .c     (c_if)
  );

  initial begin
    clk90 = 1'b0;
    forever #5 clk90 = ~clk90;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk90);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    {m0_if.adr, m0_if.wdat, m0_if.mask, m0_if.reg_space, m0_if.rrq, m0_if.wrq, m0_if.busy} = '0;
    {m1_if.adr, m1_if.wdat, m1_if.mask, m1_if.reg_space, m1_if.rrq, m1_if.wrq, m1_if.busy} = '0;
    {c_if.rdat, c_if.ready, c_if.valid, c_if.busy, c_if.err, c_if.gnt, c_if.timeout} = '0;
    #2;
    chk("rst_m0_gnt", m0_if.gnt, 0);
    chk("rst_c_rrq", c_if.rrq, 0);
    chk("rst_err", {m0_if.err, m1_if.err}, 0);
    chk("rst_timeout", {m0_if.timeout, m1_if.timeout}, 0);
    tick();
    rst = 1'b0;

    // Single read from port 0
    m0_if.adr = 32'h100;
    m0_if.rrq = 1'b1;
    #1;
    chk("rd_gnt_before_edge", m0_if.gnt, 0);
    chk("rd_c_rrq_before_edge", c_if.rrq, 0);
    tick();
    chk("rd_m0_gnt", m0_if.gnt, 1);
    chk("rd_m1_gnt", m1_if.gnt, 0);
    chk("rd_c_rrq", c_if.rrq, 1);
    chk("rd_c_adr", c_if.adr, 32'h100);
    c_if.valid = 1'b1;
    c_if.rdat  = 16'hBEEF;
    #1;
    chk("rd_m0_valid", m0_if.valid, 1);
    chk("rd_m1_valid", m1_if.valid, 0);
    chk("rd_m0_dat", m0_if.rdat, 16'hBEEF);
    chk("rd_m1_dat", m1_if.rdat, 16'hBEEF);
    c_if.valid = 1'b0;
    m0_if.rrq  = 1'b0;
    #1;
    chk("rd_drop_c_rrq", c_if.rrq, 0);
    tick();
    chk("rd_release_gnt", m0_if.gnt, 1);
    tick();
    chk("rd_idle_gnt", m0_if.gnt, 0);

    // Contention after reset, round-robin order
    pulse_rst();
    m0_if.wdat = 16'h1234;
    m0_if.wrq  = 1'b1;
    m1_if.adr  = 32'h200;
    m1_if.rrq  = 1'b1;
    tick();
    chk("rr1_m0_gnt", m0_if.gnt, 1);
    chk("rr1_m1_gnt", m1_if.gnt, 0);
    chk("rr1_c_wrq", c_if.wrq, 1);
    chk("rr1_c_rrq", c_if.rrq, 0);
    chk("rr1_c_wdat", c_if.wdat, 16'h1234);
    c_if.ready = 1'b1;
    #1;
    chk("rr1_ready", {m1_if.ready, m0_if.ready}, 2'b01);
    c_if.ready = 1'b0;
    m0_if.wrq  = 1'b0;
    c_if.busy  = 1'b1;
    tick();
    chk("rr1_release_gnt", {m1_if.gnt, m0_if.gnt}, 2'b01);
    tick();
    chk("rr1_busy_gnt", {m1_if.gnt, m0_if.gnt}, 2'b01);
    c_if.busy = 1'b0;
    tick();
    chk("rr1_idle_gnt", {m1_if.gnt, m0_if.gnt}, 2'b00);
    tick();
    chk("rr2_m1_gnt", {m1_if.gnt, m0_if.gnt}, 2'b10);
    chk("rr2_c_adr", c_if.adr, 32'h200);
    chk("rr2_c_rrq", c_if.rrq, 1);
    m0_if.rrq = 1'b1;
    m1_if.rrq = 1'b0;
    tick();
    tick();
    chk("rr2_idle_gnt", {m1_if.gnt, m0_if.gnt}, 2'b00);
    m1_if.rrq = 1'b1;
    tick();
    chk("rr3_m0_wins", {m1_if.gnt, m0_if.gnt}, 2'b01);
    m0_if.rrq = 1'b0;
    tick();
    tick();
    tick();
    chk("rr4_m1_gnt", {m1_if.gnt, m0_if.gnt}, 2'b10);

    // Read wins over write; release held while busy
    m1_if.wrq = 1'b1;
    #1;
    chk("rw_both_c_rrq", c_if.rrq, 1);
    chk("rw_both_c_wrq", c_if.wrq, 0);
    m1_if.rrq = 1'b0;
    #1;
    chk("rw_wr_c_wrq", c_if.wrq, 1);
    chk("rw_wr_c_rrq", c_if.rrq, 0);
    c_if.busy = 1'b1;
    m1_if.wrq = 1'b0;
    #1;
    chk("rel_drop_c_wrq", c_if.wrq, 0);
    tick();
    chk("rel_c1_gnt", m1_if.gnt, 1);
    tick();
    chk("rel_c2_gnt", m1_if.gnt, 1);
    tick();
    c_if.busy = 1'b0;
    chk("rel_c3_gnt", m1_if.gnt, 1);
    tick();
    chk("rel_c4_idle", m1_if.gnt, 0);

    // Controller error during a port 0 read
    m0_if.rrq = 1'b1;
    tick();
    chk("err_pre_gnt", m0_if.gnt, 1);
    c_if.err = 1'b1;
    tick();
    c_if.err = 1'b0;
    chk("err_c_rrq", c_if.rrq, 0);
    chk("err_gnt", {m1_if.gnt, m0_if.gnt}, 2'b00);
    chk("err_flags", {m1_if.err, m0_if.err}, 2'b11);
    tick();
    tick();
    c_if.valid = 1'b1;
    #1;
    chk("err_sticky", {m1_if.err, m0_if.err}, 2'b11);
    chk("err_no_regrant", m0_if.gnt, 0);
    chk("err_no_valid", m0_if.valid, 0);
    c_if.valid = 1'b0;
    pulse_rst();
    chk("err_cleared", {m1_if.err, m0_if.err}, 2'b00);

    // Asynchronous reset in HOLD, then port 0 wins
    tick();
    m1_if.rrq = 1'b1;
    m0_if.rrq = 1'b0;
    tick();
    m1_if.rrq = 1'b0;
    tick();
    tick();
    m0_if.rrq = 1'b1;
    tick();
    chk("ar_hold_gnt", m0_if.gnt, 1);
    m1_if.rrq = 1'b1;
    rst = 1'b1;
    #1;
    chk("ar_async_gnt", {m1_if.gnt, m0_if.gnt}, 2'b00);
    chk("ar_async_c_rrq", c_if.rrq, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_m0_wins", {m1_if.gnt, m0_if.gnt}, 2'b01);
    m0_if.rrq = 1'b0;
    m1_if.rrq = 1'b0;
    pulse_rst();

`ifdef HBUS_ARB_WATCHDOG_EN
    // Watchdog fires after TMO silent HOLD cycles and blocks port 0
    m0_if.rrq = 1'b1;
    tick();
    chk("wd_gnt", m0_if.gnt, 1);
    repeat (TMO - 1) tick();
    chk("wd_last_hold_rrq", c_if.rrq, 1);
    chk("wd_no_early_tmo", m0_if.timeout, 0);
    tick();
    chk("wd_rrq_dropped", c_if.rrq, 0);
    chk("wd_tmo_pulse", m0_if.timeout, 1);
    m1_if.rrq = 1'b1;
    tick();
    chk("wd_tmo_single", m0_if.timeout, 0);
    tick();
    chk("wd_m1_served", {m1_if.gnt, m0_if.gnt}, 2'b10);
    m1_if.rrq = 1'b0;
    tick();
    tick();
    tick();
    chk("wd_m0_blocked", m0_if.gnt, 0);
    m0_if.rrq = 1'b0;
    tick();
    m0_if.rrq = 1'b1;
    tick();
    chk("wd_unblocked", m0_if.gnt, 1);
`else
    // Without the watchdog a silent request is held indefinitely
    m0_if.rrq = 1'b1;
    tick();
    chk("nowd_gnt", m0_if.gnt, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen = seen | m0_if.timeout | m1_if.timeout;
    end
    chk("nowd_no_timeout", seen, 0);
    chk("nowd_rrq_held", c_if.rrq, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
